ifetch_unit: RTL and testbench

- Instruction-fetch stage. Consumes the registered next-PC from the PC control logic and fetches the word from instruction memory over a req/ready/rvalid handshake.
- Presents the fetched instruction and its PC to decode.
- Drives the stall and PC feedback back into the PC control logic.
- Holds at most one outstanding memory request. Supports flush on taken branch/jump.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/if_timeout_ctr.sv | 39 +++
 rtl/ifetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_ifetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default NOP word and the wait-counter width.
package ifetch_pkg;

    localparam int IF_STATE_W    = 3;
    localparam int IF_WAIT_CTR_W = 8;

    typedef enum logic [IF_STATE_W-1:0] {
        IF_IDLE    = 3'd0,
        IF_REQ     = 3'd1,
        IF_WAIT    = 3'd2,
        IF_VALID   = 3'd3,
        IF_DISCARD = 3'd4
    } if_state_e;

    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

    // Instruction memory is word addressed; the low byte-offset bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_timeout_ctr.sv
// Wait-cycle counter for the fetch stage: counts WAIT/DISCARD cycles and flags
// the cycle on which the response has been outstanding TIMEOUT_CYCLES cycles.
module if_timeout_ctr
    import ifetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [IF_WAIT_CTR_W-1:0] LAST_COUNT = IF_WAIT_CTR_W'(TIMEOUT_CYCLES - 1);

    logic [IF_WAIT_CTR_W-1:0] count_q;
    logic [IF_WAIT_CTR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {IF_WAIT_CTR_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expired = inc && !clear && (count_q == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding request, flush support, stall feedback.
// Optional response timeout with sticky fetchFault when IFETCH_TIMEOUT_EN is defined.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = IF_NOP_INSTR,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] nextPC,
    input  logic        flush,
    input  logic        decodeStall,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memReady,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic [31:0] instr,
    output logic [31:0] instrPC,
    output logic        instrValid,
    output logic [31:0] PC,
    output logic        stall,
    output logic        fetchFault
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        first_q, first_d;
    logic [31:0] fetch_addr;
    logic        timeout_hit;
    logic        timeout_fire;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        first_d       = first_q;
        timeout_fire  = 1'b0;
        // The very first fetch after reset ignores nextPC.
        fetch_addr    = first_q ? word_align(RESET_PC) : word_align(nextPC);

        case (state_q)
            IF_IDLE: begin
                if (flush) begin
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                end else begin
                    pc_d       = fetch_addr;
                    mem_addr_d = fetch_addr;
                    mem_req_d  = 1'b1;
                    first_d    = 1'b0;
                    state_d    = IF_REQ;
                end
            end
            IF_REQ: begin
                // An accepted request still owes a response, so a flush must drain it.
                if (memReady) begin
                    mem_req_d = 1'b0;
                    state_d   = flush ? IF_DISCARD : IF_WAIT;
                end else if (flush) begin
                    mem_req_d = 1'b0;
                    state_d   = IF_IDLE;
                end
            end
            IF_WAIT: begin
                if (flush) begin
                    state_d = memRvalid ? IF_IDLE : IF_DISCARD;
                end else if (memRvalid) begin
                    instr_d       = memRdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = IF_VALID;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_d      = IF_IDLE;
                end
            end
            IF_VALID: begin
                if (flush || !decodeStall) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = IF_IDLE;
                end
            end
            IF_DISCARD: begin
                if (memRvalid) begin
                    state_d = IF_IDLE;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_d      = IF_IDLE;
                end
            end
            default: begin
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
                instr_d       = NOP_INSTR;
                state_d       = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= word_align(RESET_PC);
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            first_q       <= first_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    logic wait_clear;
    logic wait_inc;
    logic fault_q, fault_d;

    assign wait_clear = (state_q == IF_REQ) && memReady;
    assign wait_inc   = (state_q == IF_WAIT) || (state_q == IF_DISCARD);
    assign fault_d    = fault_q | timeout_fire;

    if_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wait_clear),
        .inc    (wait_inc),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetchFault = fault_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign fetchFault     = 1'b0;
    assign unused_timeout = ^{timeout_fire, 32'(TIMEOUT_CYCLES)};
`endif

    // PC control advances only when decode takes the instruction this cycle.
    assign stall      = !((state_q == IF_VALID) && !decodeStall);
    assign memReq     = mem_req_q;
    assign memAddr    = mem_addr_q;
    assign instr      = instr_q;
    assign instrPC    = instr_pc_q;
    assign instrValid = instr_valid_q;
    assign PC         = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table of fetch transactions,
// scoreboard of delivered instructions, and hand-written flush/timeout sequences.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] nextPC;
    logic        flush;
    logic        decodeStall;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic        instrValid;
    logic [31:0] PC;
    logic        stall;
    logic        fetchFault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        int          ds_cyc;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    sb_t  exp_q[$];
    vec_t vecs[6];

    ifetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nextPC     (nextPC),
        .flush      (flush),
        .decodeStall(decodeStall),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memReady   (memReady),
        .memRvalid  (memRvalid),
        .memRdata   (memRdata),
        .instr      (instr),
        .instrPC    (instrPC),
        .instrValid (instrValid),
        .PC         (PC),
        .stall      (stall),
        .fetchFault (fetchFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard: each new instrValid must match the oldest expected delivery.
    initial begin
        logic prev_v;
        sb_t  e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (instrValid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got instr %h pc %h expected no delivery", instr, instrPC);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_instr", instr, e.instr);
                        check("sb_pc", instrPC, e.pc);
                    end
                end
                if (!instrValid) check("nop_when_invalid", instr, NOP);
                prev_v = instrValid;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    // Full fetch: starts and ends at the falling edge of an IDLE cycle.
    task automatic do_fetch(input vec_t v);
        logic got;
        nextPC      = v.npc;
        memReady    = 1'b0;
        memRvalid   = 1'b0;
        decodeStall = 1'b0;
        got         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (memReq) begin
                got = 1'b1;
                break;
            end
            next_cycle();
            sample();
        end
        if (memReq) got = 1'b1;
        check("req_seen", 32'(got), 32'd1);
        if (!got) return;
        check("req_addr", memAddr, v.exp_addr);
        check("req_pc", PC, v.exp_addr);
        for (int i = 0; i < v.rdy_dly; i++) begin
            next_cycle();
            sample();
            check("req_held", 32'(memReq), 32'd1);
            check("addr_held", memAddr, v.exp_addr);
        end
        memReady = 1'b1;
        next_cycle();
        memReady = 1'b0;
        sample();
        check("req_drop", 32'(memReq), 32'd0);
        for (int i = 0; i < v.rv_dly; i++) begin
            check("wait_invalid", 32'(instrValid), 32'd0);
            next_cycle();
            sample();
        end
        memRvalid = 1'b1;
        memRdata  = v.rdata;
        exp_q.push_back('{instr: v.rdata, pc: v.exp_addr});
        next_cycle();
        memRvalid = 1'b0;
        memRdata  = 32'hA5A5_A5A5;
        sample();
        check("valid_up", 32'(instrValid), 32'd1);
        for (int i = 0; i < v.ds_cyc; i++) begin
            decodeStall = 1'b1;
            memRvalid   = 1'b1;  // stray response while VALID must be ignored
            #1;
            check("stall_held", 32'(stall), 32'd1);
            next_cycle();
            memRvalid = 1'b0;
            sample();
            check("hold_valid", 32'(instrValid), 32'd1);
            check("hold_instr", instr, v.rdata);
            check("hold_pc", instrPC, v.exp_addr);
            check("hold_noreq", 32'(memReq), 32'd0);
        end
        decodeStall = 1'b0;
        #1;
        check("stall_release", 32'(stall), 32'd0);
        next_cycle();
        sample();
        check("idle_invalid", 32'(instrValid), 32'd0);
        check("idle_stall", 32'(stall), 32'd1);
        check("idle_noreq", 32'(memReq), 32'd0);
    endtask

    // From an IDLE falling edge: request npc, accept it, end in WAIT.
    task automatic issue_and_accept(input logic [31:0] npc, input logic [31:0] exp_addr);
        nextPC = npc;
        next_cycle();
        sample();
        check("ia_req", 32'(memReq), 32'd1);
        check("ia_addr", memAddr, exp_addr);
        memReady = 1'b1;
        next_cycle();
        memReady = 1'b0;
        sample();
        check("ia_accepted", 32'(memReq), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{npc: 32'h0000_0100, rdata: 32'h2008_0005, rdy_dly: 0, rv_dly: 0, ds_cyc: 0, exp_addr: 32'h0000_0000};
        vecs[1] = '{npc: 32'h0000_0004, rdata: 32'h8C09_0004, rdy_dly: 0, rv_dly: 0, ds_cyc: 3, exp_addr: 32'h0000_0004};
        vecs[2] = '{npc: 32'h0000_0010, rdata: 32'hAC0A_0008, rdy_dly: 4, rv_dly: 0, ds_cyc: 0, exp_addr: 32'h0000_0010};
        vecs[3] = '{npc: 32'h0000_0023, rdata: 32'h0109_5020, rdy_dly: 1, rv_dly: 2, ds_cyc: 1, exp_addr: 32'h0000_0020};
        vecs[4] = '{npc: 32'hFFFF_FFFC, rdata: 32'hFFFF_FFFF, rdy_dly: 0, rv_dly: 3, ds_cyc: 0, exp_addr: 32'hFFFF_FFFC};
        vecs[5] = '{npc: 32'h0000_0008, rdata: 32'h0000_0000, rdy_dly: 0, rv_dly: 0, ds_cyc: 2, exp_addr: 32'h0000_0008};

        rst_n       = 1'b0;
        nextPC      = 32'h0000_0100;
        flush       = 1'b0;
        decodeStall = 1'b0;
        memReady    = 1'b0;
        memRvalid   = 1'b0;
        memRdata    = 32'hA5A5_A5A5;
        repeat (3) next_cycle();
        sample();
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_memAddr", memAddr, 32'h0000_0000);
        check("rst_instr", instr, NOP);
        check("rst_instrPC", instrPC, 32'h0000_0000);
        check("rst_instrValid", 32'(instrValid), 32'd0);
        check("rst_PC", PC, 32'h0000_0000);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_fault", 32'(fetchFault), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("post_rst_noreq", 32'(memReq), 32'd0);

        for (int i = 0; i < 6; i++) begin
            $display("vector %0d: npc=%h addr=%h", i, vecs[i].npc, vecs[i].exp_addr);
            do_fetch(vecs[i]);
        end

        // Flush in WAIT; the late response must be dropped.
        $display("seq flush_in_wait");
        issue_and_accept(32'h0000_0030, 32'h0000_0030);
        flush  = 1'b1;
        nextPC = 32'h0000_0040;
        next_cycle();
        flush = 1'b0;
        sample();
        check("fw_noreq", 32'(memReq), 32'd0);
        check("fw_invalid", 32'(instrValid), 32'd0);
        check("fw_stall", 32'(stall), 32'd1);
        next_cycle();
        sample();
        check("fw_still_draining", 32'(memReq), 32'd0);
        memRvalid = 1'b1;
        memRdata  = 32'hDEAD_BEEF;
        next_cycle();
        memRvalid = 1'b0;
        sample();
        check("fw_drop_invalid", 32'(instrValid), 32'd0);
        do_fetch('{npc: 32'h0000_0040, rdata: 32'h1234_5678, rdy_dly: 0, rv_dly: 0, ds_cyc: 0, exp_addr: 32'h0000_0040});

        // Flush together with the response in WAIT: back to IDLE at once.
        $display("seq flush_with_rvalid");
        issue_and_accept(32'h0000_0050, 32'h0000_0050);
        flush     = 1'b1;
        memRvalid = 1'b1;
        memRdata  = 32'hBADB_AD00;
        nextPC    = 32'h0000_0060;
        next_cycle();
        flush     = 1'b0;
        memRvalid = 1'b0;
        sample();
        check("fr_invalid", 32'(instrValid), 32'd0);
        check("fr_noreq", 32'(memReq), 32'd0);
        next_cycle();
        sample();
        check("fr_idle_next", 32'(memReq), 32'd1);
        check("fr_addr", memAddr, 32'h0000_0060);
        memReady = 1'b1;
        next_cycle();
        memReady  = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 32'h0BAD_F00D;
        exp_q.push_back('{instr: 32'h0BAD_F00D, pc: 32'h0000_0060});
        next_cycle();
        memRvalid = 1'b0;
        sample();
        check("fr_valid", 32'(instrValid), 32'd1);
        next_cycle();
        sample();
        check("fr_back_idle", 32'(instrValid), 32'd0);

        // Flush in REQ with memReady: request counts as accepted, drain it.
        $display("seq flush_in_req_ready");
        nextPC = 32'h0000_0080;
        next_cycle();
        sample();
        check("fq_req", 32'(memReq), 32'd1);
        memReady = 1'b1;
        flush    = 1'b1;
        nextPC   = 32'h0000_0090;
        next_cycle();
        memReady = 1'b0;
        flush    = 1'b0;
        sample();
        check("fq_noreq", 32'(memReq), 32'd0);
        next_cycle();
        sample();
        check("fq_discarding", 32'(memReq), 32'd0);
        memRvalid = 1'b1;
        memRdata  = 32'h1357_9BDF;
        next_cycle();
        memRvalid = 1'b0;
        sample();
        check("fq_invalid", 32'(instrValid), 32'd0);
        do_fetch('{npc: 32'h0000_0090, rdata: 32'h2468_ACE0, rdy_dly: 0, rv_dly: 1, ds_cyc: 0, exp_addr: 32'h0000_0090});

`ifdef IFETCH_TIMEOUT_EN
        $display("seq timeout");
        issue_and_accept(32'h0000_00A0, 32'h0000_00A0);
        for (int i = 0; i < 15; i++) begin
            check("to_not_yet", 32'(fetchFault), 32'd0);
            next_cycle();
            sample();
        end
        check("to_cycle16", 32'(fetchFault), 32'd0);
        next_cycle();
        sample();
        check("to_fault_set", 32'(fetchFault), 32'd1);
        check("to_idle_noreq", 32'(memReq), 32'd0);
        do_fetch('{npc: 32'h0000_0070, rdata: 32'h0F0F_0F0F, rdy_dly: 0, rv_dly: 0, ds_cyc: 0, exp_addr: 32'h0000_0070});
        check("to_fault_sticky", 32'(fetchFault), 32'd1);
`else
        check("fault_tied_low", 32'(fetchFault), 32'd0);
`endif

        repeat (2) next_cycle();
        sample();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
